ama_riscv_perf_event_gen: RTL



---
 rtl/ama_riscv_perf_event_gen_if.sv | 65 ++++++
 rtl/ama_riscv_perf_event_gen.sv | 108 ++++++++++
 2 files changed

// File: rtl/ama_riscv_perf_event_gen_if.sv
// Pipeline status in, registered perf events out.
// Optional freeze input under PERF_EVENT_FREEZE_EN.
package ama_riscv_perf_pkg;

  typedef struct packed {
    logic bad_spec;
    logic be;
    logic be_dc;
    logic fe;
    logic fe_ic;
    logic ret_simd;
  } perf_event_t;

endpackage

interface ama_riscv_perf_event_gen_if;
  import ama_riscv_perf_pkg::*;

`ifdef PERF_EVENT_FREEZE_EN
  logic        freeze;
`endif
  logic        dec_valid;
  logic        fe_stall;
  logic        ic_miss;
  logic        be_stall;
  logic        dc_miss;
  logic        flush;
  logic        ret_valid;
  logic        ret_simd;
  perf_event_t perf_event;
  logic        inst_to_be_retired;

  modport master (
`ifdef PERF_EVENT_FREEZE_EN
    output freeze,
`endif
    output dec_valid,
    output fe_stall,
    output ic_miss,
    output be_stall,
    output dc_miss,
    output flush,
    output ret_valid,
    output ret_simd,
    input  perf_event,
    input  inst_to_be_retired
  );

  modport slave (
`ifdef PERF_EVENT_FREEZE_EN
    input  freeze,
`endif
    input  dec_valid,
    input  fe_stall,
    input  ic_miss,
    input  be_stall,
    input  dc_miss,
    input  flush,
    input  ret_valid,
    input  ret_simd,
    output perf_event,
    output inst_to_be_retired
  );

endinterface

// File: rtl/ama_riscv_perf_event_gen.sv
// Per-cycle issue-slot classifier for the hpm counters.
// Define PERF_EVENT_FREEZE_EN to add the freeze input.
module ama_riscv_perf_event_gen
  import ama_riscv_perf_pkg::*;
#(
  parameter int unsigned FLUSH_SHADOW = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  ama_riscv_perf_event_gen_if.slave bus
);

  localparam logic [3:0] SH_LOAD = 4'(FLUSH_SHADOW);

  typedef enum logic {
    IDLE,
    SHADOW
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  sh_cnt_q;
  logic [3:0]  sh_cnt_d;
  logic        in_shadow;
  perf_event_t ev_d;

  // Shadow FSM: refill bubbles after a redirect belong to bad spec.
  always_comb begin
    state_d  = state_q;
    sh_cnt_d = sh_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d  = SHADOW;
          sh_cnt_d = SH_LOAD;
        end
      end
      SHADOW: begin
        if (bus.flush) begin
          state_d  = SHADOW;
          sh_cnt_d = SH_LOAD;
        end else if (bus.dec_valid || sh_cnt_q == 4'd1) begin
          state_d  = IDLE;
          sh_cnt_d = 4'd0;
        end else begin
          sh_cnt_d = sh_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        sh_cnt_d = 4'd0;
      end
    endcase
  end

  // Mutually exclusive top-level slot attribution plus sub-events.
  always_comb begin
    ev_d      = '0;
    in_shadow = bus.flush | (state_q == SHADOW);
    ev_d.be   = bus.be_stall;
    ev_d.bad_spec = !bus.be_stall
                  & in_shadow
                  & !bus.dec_valid;
    ev_d.fe   = !bus.be_stall
              & !in_shadow
              & bus.fe_stall
              & !bus.dec_valid;
    ev_d.be_dc    = ev_d.be & bus.dc_miss;
    ev_d.fe_ic    = ev_d.fe & bus.ic_miss;
    ev_d.ret_simd = bus.ret_valid & bus.ret_simd;
`ifdef PERF_EVENT_FREEZE_EN
    if (bus.freeze) begin
      ev_d = '0;
    end
`endif
  end

  // FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      sh_cnt_q <= sh_cnt_d;
    end
  end

  // Registered outputs, one cycle after sampling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.perf_event         <= '0;
      bus.inst_to_be_retired <= 1'b0;
    end else begin
      bus.perf_event         <= ev_d;
      bus.inst_to_be_retired <= bus.ret_valid;
    end
  end

  // At most one top-level event per slot.
  a_onehot : assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0({bus.perf_event.be,
              bus.perf_event.bad_spec,
              bus.perf_event.fe})
  );

endmodule
